// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - multiplexed scan sequencer for an N-digit common-anode 7-segment display
// Shadow-loaded digit data is applied only at frame boundaries so a frame never mixes old and new values.
module seg7_scan_controller #(
    parameter int NUM_DIGITS  = 8,
    parameter int ON_TICKS    = 1,
    parameter int BLANK_TICKS = 1,
    parameter int TCNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    tick,
    output logic                    cnt_en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    output logic                    pending,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [TCNT_W-1:0]       tcnt_q, tcnt_d, tcnt_inc;
    logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   act_mask_q, act_mask_d, sh_mask_q, sh_mask_d;
    logic                    pending_q, pending_d;
    logic                    frame_done_q, frame_done_d;
    logic                    cnt_en_q, cnt_en_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    boundary, advance;
    logic [3:0]              cur_digit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tcnt_d       = tcnt_q;
        tcnt_inc     = tcnt_q + 1'b1;
        boundary     = 1'b0;
        advance      = 1'b0;
        frame_done_d = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A tick coinciding with the start of scanning is deliberately not counted.
                    state_d  = SHOW;
                    idx_d    = '0;
                    tcnt_d   = '0;
                    boundary = 1'b1;
                end
                SHOW: begin
                    if (tick) begin
                        if (tcnt_inc == TCNT_W'(ON_TICKS)) begin
                            tcnt_d = '0;
                            if (BLANK_TICKS == 0) advance = 1'b1;
                            else                  state_d = BLANK;
                        end else begin
                            tcnt_d = tcnt_inc;
                        end
                    end
                end
                BLANK: begin
                    if (tick) begin
                        if (tcnt_inc == TCNT_W'(BLANK_TICKS)) begin
                            tcnt_d  = '0;
                            advance = 1'b1;
                        end else begin
                            tcnt_d = tcnt_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (advance) begin
            state_d = SHOW;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d        = '0;
                frame_done_d = 1'b1;
                boundary     = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        sh_dig_d   = load ? digits_in  : sh_dig_q;
        sh_dp_d    = load ? dp_in      : sh_dp_q;
        sh_mask_d  = load ? digit_mask : sh_mask_q;
        act_dig_d  = act_dig_q;
        act_dp_d   = act_dp_q;
        act_mask_d = act_mask_q;
        pending_d  = pending_q;

        if (boundary) begin
            pending_d = 1'b0;
            // A load landing on the boundary bypasses the shadow entirely.
            if (load) begin
                act_dig_d  = digits_in;
                act_dp_d   = dp_in;
                act_mask_d = digit_mask;
            end else if (pending_q) begin
                act_dig_d  = sh_dig_q;
                act_dp_d   = sh_dp_q;
                act_mask_d = sh_mask_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        an_d      = '1;
        seg_d     = 7'h7F;
        dp_d      = 1'b1;
        cnt_en_d  = (state_d != IDLE);
        cur_digit = act_dig_d[{idx_d, 2'b00} +: 4];
        if (state_d == SHOW) begin
            seg_d = hex_to_seg(cur_digit);
            if (act_mask_d[idx_d]) begin
                an_d[idx_d] = 1'b0;
                dp_d        = ~act_dp_d[idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            tcnt_q       <= '0;
            act_dig_q    <= '0;
            act_dp_q     <= '0;
            act_mask_q   <= '0;
            sh_dig_q     <= '0;
            sh_dp_q      <= '0;
            sh_mask_q    <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_en_q     <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tcnt_q       <= tcnt_d;
            act_dig_q    <= act_dig_d;
            act_dp_q     <= act_dp_d;
            act_mask_q   <= act_mask_d;
            sh_dig_q     <= sh_dig_d;
            sh_dp_q      <= sh_dp_d;
            sh_mask_q    <= sh_mask_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            cnt_en_q     <= cnt_en_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign cnt_en     = cnt_en_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb/tb_seg7_scan_controller.sv - scoreboard bench for seg7_scan_controller (4 digits, ON=2, BLANK=1)
module tb_seg7_scan_controller;
    localparam int N  = 4;
    localparam int ON = 2;
    localparam int BL = 1;

    logic          clk = 1'b0;
    logic          rst, enable, tick, load;
    logic [4*N-1:0] digits_in;
    logic [N-1:0]  dp_in, digit_mask;
    logic          cnt_en, pending, frame_done, dp;
    logic [N-1:0]  an;
    logic [6:0]    seg;

    seg7_scan_controller #(.NUM_DIGITS(N), .ON_TICKS(ON), .BLANK_TICKS(BL), .TCNT_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick), .cnt_en(cnt_en),
        .load(load), .digits_in(digits_in), .dp_in(dp_in), .digit_mask(digit_mask),
        .pending(pending), .frame_done(frame_done), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model of the scan sequence, kept as plain counters.
    logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    bit         m_run, m_blank, m_pend;
    int         m_idx, m_cnt;
    logic [4*N-1:0] m_act_dig, m_sh_dig;
    logic [N-1:0]   m_act_dp, m_sh_dp, m_act_mask, m_sh_mask;
    logic [14:0]    sb_q[$];
    int             fd_seen;

    function automatic logic [14:0] model_edge();
        bit bnd, fd;
        logic [N-1:0] e_an;
        logic [6:0]   e_seg;
        logic         e_dp;
        logic [3:0]   d;
        bnd = 0; fd = 0;
        if (rst) begin
            m_run = 0; m_blank = 0; m_pend = 0; m_idx = 0; m_cnt = 0;
            m_act_dig = '0; m_sh_dig = '0; m_act_dp = '0; m_sh_dp = '0;
            m_act_mask = '0; m_sh_mask = '0;
        end else begin
            if (!enable) begin
                m_run = 0; m_idx = 0; m_cnt = 0;
            end else if (!m_run) begin
                m_run = 1; m_blank = 0; m_idx = 0; m_cnt = 0; bnd = 1;
            end else if (tick) begin
                m_cnt++;
                if (m_cnt == (m_blank ? BL : ON)) begin
                    m_cnt = 0;
                    if (!m_blank) m_blank = 1;
                    else begin
                        m_blank = 0;
                        if (m_idx == N - 1) begin m_idx = 0; fd = 1; bnd = 1; end
                        else m_idx++;
                    end
                end
            end
            if (bnd && load) begin
                m_act_dig = digits_in; m_act_dp = dp_in; m_act_mask = digit_mask; m_pend = 0;
            end else if (bnd && m_pend) begin
                m_act_dig = m_sh_dig; m_act_dp = m_sh_dp; m_act_mask = m_sh_mask; m_pend = 0;
            end else if (load) begin
                m_pend = 1;
            end
            if (load) begin m_sh_dig = digits_in; m_sh_dp = dp_in; m_sh_mask = digit_mask; end
        end
        e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
        if (m_run && !m_blank) begin
            d = 4'((m_act_dig >> (4 * m_idx)) & 16'hF);
            e_seg = lut[d];
            if (m_act_mask[m_idx]) begin
                e_an = ~(N'(1) << m_idx);
                e_dp = ~m_act_dp[m_idx];
            end
        end
        return {e_an, e_seg, e_dp, m_run, fd, m_pend};
    endfunction

    task automatic cycle();
        logic [14:0] exp;
        sb_q.push_back(model_edge());
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check("scoreboard", {17'b0, an, seg, dp, cnt_en, frame_done, pending}, {17'b0, exp});
        if (frame_done) fd_seen++;
        tick = 1'b0;
        load = 1'b0;
    endtask

    // One tick every 'per' cycles, starting with the idle cycles.
    task automatic run_ticks(input int nticks, input int per);
        for (int t = 0; t < nticks; t++) begin
            for (int c = 0; c < per - 1; c++) cycle();
            tick = 1'b1;
            cycle();
        end
    endtask

    task automatic drive_load(input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] mk);
        load = 1'b1; digits_in = dg; dp_in = dpv; digit_mask = mk;
    endtask

    initial begin
        int guard;
        rst = 1'b1; enable = 1'b0; tick = 1'b0; load = 1'b0;
        digits_in = '0; dp_in = '0; digit_mask = '0; fd_seen = 0;
        cycle(); cycle();
        check("reset_outputs", {16'b0, an, seg, dp, cnt_en, pending, frame_done},
              {16'b0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        cycle();

        drive_load(16'h3210, 4'b0100, 4'hF);
        cycle();
        check("pending_after_load", 32'(pending), 32'd1);
        enable = 1'b1;
        cycle();
        check("enter_pending", 32'(pending), 32'd0);
        check("enter_an", 32'(an), 32'hE);
        check("enter_seg", 32'(seg), 32'h40);
        run_ticks(2, 3);
        check("blank_an", 32'(an), 32'hF);
        run_ticks(1, 3);
        check("digit1_an", 32'(an), 32'hD);
        check("digit1_seg", 32'(seg), 32'h79);
        run_ticks(3, 3);
        check("digit2_seg", 32'(seg), 32'h24);
        check("digit2_dp", 32'(dp), 32'd0);

        // 6 ticks into the frame; 30 more close out 3 frames.
        fd_seen = 0;
        run_ticks(30, 5);
        check("frame_done_count", 32'(fd_seen), 32'd3);

        run_ticks(3, 4);
        drive_load(16'hFFFF, 4'h0, 4'hF);
        cycle();
        run_ticks(2, 4);
        drive_load(16'h8888, 4'hF, 4'hF);
        cycle();
        check("pend_midframe", 32'(pending), 32'd1);
        run_ticks(14, 4);

        guard = 0;
        while (!(m_run && m_blank && m_idx == N - 1 && m_cnt == BL - 1) && guard < 200) begin
            run_ticks(1, 2);
            guard++;
        end
        check("reach_last_blank", 32'(guard < 200), 32'd1);
        drive_load(16'hAAAA, 4'h0, 4'b1010);
        tick = 1'b1;
        cycle();
        check("bypass_fd", 32'(frame_done), 32'd1);
        check("bypass_pending", 32'(pending), 32'd0);
        check("bypass_seg", 32'(seg), 32'h08);
        check("masked_an0", 32'(an), 32'hF);
        run_ticks(16, 3);

        guard = 0;
        while (!(m_run && !m_blank && m_idx == 2) && guard < 200) begin
            run_ticks(1, 2);
            guard++;
        end
        check("reach_digit2", 32'(guard < 200), 32'd1);
        enable = 1'b0;
        cycle();
        check("off_an", 32'(an), 32'hF);
        check("off_cnt_en", 32'(cnt_en), 32'd0);
        check("off_fd", 32'(frame_done), 32'd0);
        run_ticks(3, 2);
        enable = 1'b1;
        tick = 1'b1;
        cycle();
        check("restart_seg", 32'(seg), 32'h08);
        run_ticks(5, 3);

        for (int i = 0; i < 60; i++) begin
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0)
                drive_load(16'($urandom), 4'($urandom), 4'($urandom));
            cycle();
        end

        guard = 0;
        while (!(m_run && m_blank) && guard < 200) begin
            run_ticks(1, 2);
            guard++;
        end
        check("reach_blank", 32'(guard < 200), 32'd1);
        rst = 1'b1;
        tick = 1'b1;
        cycle();
        check("midrun_reset", {16'b0, an, seg, dp, cnt_en, pending, frame_done},
              {16'b0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        cycle();
        check("cleared_seg", 32'(seg), 32'h40);
        check("cleared_an", 32'(an), 32'hF);
        run_ticks(12, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
